// File: rtl/seq_bit_serializer_if.sv
// Word handshake toward the serializer plus the serial stream it drives to the detector.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, x, x_valid, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, x, x_valid, busy
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end with a one-word holding register for gapless frames.
// Optional even-parity trailer bit per frame when SER_PARITY_EN is defined.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    seq_bit_serializer_if.slave bus
);
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [WIDTH-1:0] hold_reg, hold_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic             active, active_n;
    logic             hold_full, hold_full_n;
    logic             x_r, x_n;
    logic             x_valid_r, x_valid_n;
    logic             in_ready_r;
    logic             busy_r;
`ifdef SER_PARITY_EN
    logic             par_reg, par_n;
`endif

    logic             accept;
    logic             last_bit;
    logic             load;
    logic [WIDTH-1:0] load_word;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept   = bus.in_valid && in_ready_r;
    assign last_bit = active && (bit_cnt == CNT_W'(FRAME - 1));

    always_comb begin
        shift_n     = shift_reg;
        hold_n      = hold_reg;
        cnt_n       = bit_cnt;
        active_n    = active;
        hold_full_n = hold_full;
        x_n         = x_r;
        x_valid_n   = x_valid_r;
        load        = 1'b0;
        load_word   = bus.in_data;
`ifdef SER_PARITY_EN
        par_n       = par_reg;
`endif
        if (!active) begin
            load = accept;
        end else if (!last_bit) begin
            cnt_n   = bit_cnt + CNT_W'(1);
            x_n     = head_bit(shift_reg);
            shift_n = advance(shift_reg);
`ifdef SER_PARITY_EN
            if (bit_cnt == CNT_W'(WIDTH - 1)) x_n = par_reg;
`endif
            if (accept) begin
                hold_n      = bus.in_data;
                hold_full_n = 1'b1;
            end
        end else if (hold_full) begin
            // Held word takes over the shifter on the same edge the frame ends.
            load        = 1'b1;
            load_word   = hold_reg;
            hold_full_n = 1'b0;
        end else if (accept) begin
            load = 1'b1;
        end else begin
            active_n  = 1'b0;
            cnt_n     = '0;
            x_n       = 1'b0;
            x_valid_n = 1'b0;
        end

        if (load) begin
            active_n  = 1'b1;
            x_valid_n = 1'b1;
            cnt_n     = '0;
            x_n       = head_bit(load_word);
            shift_n   = advance(load_word);
`ifdef SER_PARITY_EN
            par_n     = ^load_word;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            hold_reg   <= '0;
            bit_cnt    <= '0;
            active     <= 1'b0;
            hold_full  <= 1'b0;
            x_r        <= 1'b0;
            x_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
`ifdef SER_PARITY_EN
            par_reg    <= 1'b0;
`endif
        end else begin
            shift_reg  <= shift_n;
            hold_reg   <= hold_n;
            bit_cnt    <= cnt_n;
            active     <= active_n;
            hold_full  <= hold_full_n;
            x_r        <= x_n;
            x_valid_r  <= x_valid_n;
            in_ready_r <= !hold_full_n;
            busy_r     <= active_n || hold_full_n;
`ifdef SER_PARITY_EN
            par_reg    <= par_n;
`endif
        end
    end

    assign bus.x        = x_r;
    assign bus.x_valid  = x_valid_r;
    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances, queue scoreboard.
module tb_seq_bit_serializer;
`ifdef SER_PARITY_EN
    localparam int FRAME = 9;
    localparam logic [31:0] LIT_DB = 32'h1B6;
    localparam logic [31:0] LIT_B6 = 32'h16D;
    localparam logic [31:0] LIT_0B = 32'h1A1;
`else
    localparam int FRAME = 8;
    localparam logic [31:0] LIT_DB = 32'hDB;
    localparam logic [31:0] LIT_B6 = 32'hB6;
    localparam logic [31:0] LIT_0B = 32'hD0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    logic        qm[$];
    logic        ql[$];
    logic [31:0] obs_m, obs_l;
    int          nvalid_m, run_m, max_run_m;

    seq_bit_serializer_if #(.WIDTH(8)) bus_m ();
    seq_bit_serializer_if #(.WIDTH(8)) bus_l ();

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .bus(bus_m)
    );
    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .bus(bus_l)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Arrival order: element 0 is the first bit on x.
    function automatic logic [8:0] frame_of(input logic [7:0] w, input bit msb);
        logic [8:0] f;
        for (int j = 0; j < 8; j++) f[j] = msb ? w[7-j] : w[j];
        f[8] = ^w;
        return f;
    endfunction

    task automatic step();
        logic       acc_m, acc_l;
        logic [7:0] dm, dl;
        logic [8:0] f;
        acc_m = bus_m.in_valid && bus_m.in_ready;
        acc_l = bus_l.in_valid && bus_l.in_ready;
        dm    = bus_m.in_data;
        dl    = bus_l.in_data;
        @(posedge clk);
        #1;
        if (acc_m) begin
            f = frame_of(dm, 1'b1);
            for (int j = 0; j < FRAME; j++) qm.push_back(f[j]);
        end
        if (acc_l) begin
            f = frame_of(dl, 1'b0);
            for (int j = 0; j < FRAME; j++) ql.push_back(f[j]);
        end
        if (bus_m.x_valid) begin
            chk("m_bit_expected", 32'(qm.size() > 0), 32'd1);
            if (qm.size() > 0) chk("m_bit", 32'(bus_m.x), 32'(qm.pop_front()));
            obs_m = {obs_m[30:0], bus_m.x};
            nvalid_m++;
            run_m++;
            if (run_m > max_run_m) max_run_m = run_m;
        end else begin
            chk("m_idle_x", 32'(bus_m.x), 32'd0);
            chk("m_gap", 32'(qm.size()), 32'd0);
            run_m = 0;
        end
        if (bus_l.x_valid) begin
            chk("l_bit_expected", 32'(ql.size() > 0), 32'd1);
            if (ql.size() > 0) chk("l_bit", 32'(bus_l.x), 32'(ql.pop_front()));
            obs_l = {obs_l[30:0], bus_l.x};
        end else begin
            chk("l_idle_x", 32'(bus_l.x), 32'd0);
            chk("l_gap", 32'(ql.size()), 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((bus_m.busy || bus_l.busy || qm.size() != 0 || ql.size() != 0) && n < 64) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 64), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_m_x"},     32'(bus_m.x),        32'd0);
        chk({tag, "_m_xv"},    32'(bus_m.x_valid),  32'd0);
        chk({tag, "_m_busy"},  32'(bus_m.busy),     32'd0);
        chk({tag, "_m_ready"}, 32'(bus_m.in_ready), 32'd1);
        chk({tag, "_l_xv"},    32'(bus_l.x_valid),  32'd0);
        chk({tag, "_l_ready"}, 32'(bus_l.in_ready), 32'd1);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus_m.in_valid = 1'b0;
        bus_m.in_data  = '0;
        bus_l.in_valid = 1'b0;
        bus_l.in_data  = '0;
        obs_m = '0; obs_l = '0; nvalid_m = 0; run_m = 0; max_run_m = 0;

        // Reset values, during reset and first cycle after release
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst_hold");
        reset_n = 1'b1;
        step();
        check_idle("post_rst");

        // Single word, MSB first
        obs_m = '0; nvalid_m = 0;
        bus_m.in_valid = 1'b1; bus_m.in_data = 8'hDB;
        step();
        bus_m.in_valid = 1'b0; bus_m.in_data = '0;
        drain("drain_single");
        chk("single_bits", obs_m, LIT_DB);
        chk("single_count", 32'(nvalid_m), 32'(FRAME));
        chk("single_xv_end", 32'(bus_m.x_valid), 32'd0);
        chk("single_busy_end", 32'(bus_m.busy), 32'd0);

        // Back-to-back words with a third held off by in_ready
        nvalid_m = 0; max_run_m = 0; run_m = 0;
        bus_m.in_valid = 1'b1; bus_m.in_data = 8'hDB;
        step();
        bus_m.in_data = 8'hB6;
        step();
        chk("b2b_ready_low", 32'(bus_m.in_ready), 32'd0);
        bus_m.in_data = 8'h3C;
        for (int i = 2; i <= FRAME; i++) begin
            step();
            chk("b2b_ready", 32'(bus_m.in_ready), 32'(i == FRAME));
        end
        step();
        chk("b2b_third_held", 32'(bus_m.in_ready), 32'd0);
        bus_m.in_valid = 1'b0; bus_m.in_data = '0;
        drain("drain_b2b");
        chk("b2b_count", 32'(nvalid_m), 32'(3 * FRAME));
        chk("b2b_contiguous", 32'(max_run_m), 32'(3 * FRAME));

        // Reset in cycle 4 of a frame with a word held
        nvalid_m = 0;
        bus_m.in_valid = 1'b1; bus_m.in_data = 8'hDB;
        step();
        bus_m.in_data = 8'hB6;
        step();
        bus_m.in_valid = 1'b0; bus_m.in_data = '0;
        step();
        step();
        chk("mid_xv_before", 32'(bus_m.x_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_idle("rst_mid");
        qm.delete();
        ql.delete();
        nvalid_m = 0;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) step();
        chk("after_rst_nothing", 32'(nvalid_m), 32'd0);
        chk("after_rst_ready", 32'(bus_m.in_ready), 32'd1);
        chk("after_rst_busy", 32'(bus_m.busy), 32'd0);

        // LSB first
        obs_l = '0;
        bus_l.in_valid = 1'b1; bus_l.in_data = 8'h0B;
        step();
        bus_l.in_valid = 1'b0; bus_l.in_data = '0;
        drain("drain_lsb");
        chk("lsb_bits", obs_l, LIT_0B);

        // Parity-sensitive pair: odd then even number of ones
        obs_m = '0;
        bus_m.in_valid = 1'b1; bus_m.in_data = 8'hB6;
        step();
        bus_m.in_valid = 1'b0; bus_m.in_data = '0;
        drain("drain_b6");
        chk("b6_bits", obs_m, LIT_B6);
        obs_m = '0;
        bus_m.in_valid = 1'b1; bus_m.in_data = 8'hDB;
        step();
        bus_m.in_valid = 1'b0; bus_m.in_data = '0;
        drain("drain_db");
        chk("db_bits", obs_m, LIT_DB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the sequence-detector path: accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per clock on `x`, the single-bit stream the Mealy sequence detector consumes. A one-word holding register lets the producer queue the next word while the current one shifts, so back-to-back words leave no idle bit between them. Sits directly upstream of the detector; `x` connects straight to the detector's `x` input.

## Interface
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset; one clock; reset polarity and synchronicity are fixed.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_data` input WIDTH: word to serialize; sampled only on an accepting edge.
- `in_ready` output 1: holding register is empty; equals `!hold_full`, driven from a register.
- `x` output 1: serial bit to the detector; registered; 0 whenever `x_valid`=0.
- `x_valid` output 1: `x` carries a frame bit this cycle.
- `busy` output 1: shifter is active or the holding register is full.

## Operation
- State: `shift_reg[WIDTH-1:0]`, `bit_cnt` (counts 0..FRAME-1), `active`, `hold_reg[WIDTH-1:0]`, `hold_full`.
- FRAME = WIDTH, or WIDTH+1 when parity is compiled in.
- Accept: when `in_valid && in_ready` at an edge.
  - If `active`=0: word loads into the shifter and `active` is set.
  - If `active`=1: word loads into `hold_reg` and `hold_full` is set.
- Shifting: each edge while active presents the next frame bit on `x`, with `x_valid`=1.
- End of frame, at the edge after the last frame bit:
  - If `hold_full`: the held word moves to the shifter, its first bit appears on `x`, and `hold_full` clears. There is no gap.
  - Else if accepting: the incoming word goes straight to the shifter.
  - Else: `active` clears, and `x`/`x_valid` go to 0.
- `in_ready` drops the cycle after the holding register fills and rises the cycle after it drains.
- `in_valid` asserted while `in_ready`=0 is ignored. The producer holds the word; it is not lost.
- Reset state: `x`=0, `x_valid`=0, `busy`=0, `in_ready`=1, all registers cleared.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous). Partial and held words are discarded and nothing resumes after release.

## Timing
- Latency: word accepted at edge k while idle → first bit on `x` during cycle k+1 (registered at edge k). Bit i appears in cycle k+1+i.
- Throughput: one bit per clock sustained; one word per FRAME cycles.
- `x_valid` stays high continuously across back-to-back frames.
- The first accepting edge after `reset_n` rises is the first rising `clk` edge with `reset_n`=1.

## Configuration
- `SER_PARITY_EN` defined:
  - Each frame gets one extra bit after the data bits: the even-parity bit (XOR of all WIDTH data bits).
  - FRAME = WIDTH+1.
- `SER_PARITY_EN` undefined:
  - No parity logic is present.
  - FRAME = WIDTH.

## Test plan
- Reset → `x`=0, `x_valid`=0, `busy`=0, `in_ready`=1 during reset and in the first cycle after release.
- WIDTH=8, MSB_FIRST=1, single word 8'b11011011 → `x`=1,1,0,1,1,0,1,1 over 8 consecutive cycles with `x_valid`=1, then `x_valid`=0 and `busy`=0.
- Words 8'hDB then 8'hB6 offered back-to-back → 16 contiguous `x_valid` cycles. `in_ready` is low from the cycle after the second accept until the second word enters the shifter, and a third word held on `in_valid` meanwhile is not accepted until `in_ready` rises.
- `reset_n` pulled low in cycle 4 of a frame, with a word held in the holding register → `x`/`x_valid` go to 0 immediately. After release nothing is emitted and `in_ready`=1.
- MSB_FIRST=0, word 8'h0B → `x`=1,1,0,1,0,0,0,0.
- `SER_PARITY_EN` defined, 8'hB6 (five ones) → 9 bits 1,0,1,1,0,1,1,0,1. Then 8'hDB (six ones) → ninth bit 0.
